// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, data-bit encodings and frame sizing.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam logic [1:0] DB5 = 2'b00;
   localparam logic [1:0] DB6 = 2'b01;
   localparam logic [1:0] DB7 = 2'b10;
   localparam logic [1:0] DB8 = 2'b11;

   // Clock cycles in one frame with bit period p: start + data + parity + stop(s).
   function automatic int unsigned frame_cycles(input int unsigned p, input logic [1:0] data_bits,
                                                input logic parity_en, input logic two_stop);
      return p * (2 + 5 + int'(data_bits) + int'(parity_en) + int'(two_stop));
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is on rdata_o whenever empty_o is low.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // NOTE: storage is deliberately not reset; level_q gates every read, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, optional parity, 1/2 stop) fed from a TX FIFO.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W = 16,
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [CNT_W-1:0] cycles_per_bit,
   input  logic [1:0]       cfg_data_bits,
   input  logic             cfg_parity_en,
   input  logic             cfg_parity_odd,
   input  logic             cfg_two_stop,
   input  logic             tx_enable,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   output logic             txd,
   output logic             busy,
   output logic [LVL_W-1:0] fifo_level
);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [2:0]       bit_q, bit_d;
   logic [2:0]       last_bit_q, last_bit_d;
   logic [7:0]       data_q, data_d;
   logic             stop_q, stop_d;
   logic             par_en_q, par_en_d;
   logic             par_odd_q, par_odd_d;
   logic             two_stop_q, two_stop_d;
   logic             txd_q, txd_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_rdata;
   logic [CNT_W-1:0] per_eff;
   logic             bit_end;
   logic             launch;
   logic             par_bit;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (s_valid),
      .wdata_i (s_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign s_ready = !fifo_full;
   assign busy    = (state_q != ST_IDLE);
   assign txd     = txd_q;

   assign per_eff = (cycles_per_bit < CNT_W'(2)) ? CNT_W'(2) : cycles_per_bit;
   assign bit_end = (cnt_q == per_q - 1'b1);
   // A new frame may start from idle or on the very last cycle of the final stop bit.
   assign launch  = (state_q == ST_IDLE || (state_q == ST_STOP && bit_end && stop_q == two_stop_q))
                    && !fifo_empty && tx_enable;
   assign par_bit = (^(data_q & (8'hFF >> (3'd7 - last_bit_q)))) ^ par_odd_q;

   // NOTE: next-state logic is purely combinational with every output defaulted first (no latches);
   // the state register below uses non-blocking assignments only.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      per_d      = per_q;
      bit_d      = bit_q;
      last_bit_d = last_bit_q;
      data_d     = data_q;
      stop_d     = stop_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      two_stop_d = two_stop_q;
      fifo_pop   = 1'b0;

      if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

      if (launch) begin
         state_d    = ST_START;
         cnt_d      = '0;
         bit_d      = '0;
         stop_d     = 1'b0;
         data_d     = fifo_rdata;
         per_d      = per_eff;
         par_en_d   = cfg_parity_en;
         par_odd_d  = cfg_parity_odd;
         two_stop_d = cfg_two_stop;
         fifo_pop   = 1'b1;
         case (cfg_data_bits)
            DB5:     last_bit_d = 3'd4;
            DB6:     last_bit_d = 3'd5;
            DB7:     last_bit_d = 3'd6;
            DB8:     last_bit_d = 3'd7;
            default: last_bit_d = 3'd7;
         endcase
      end else if (bit_end) begin
         case (state_q)
            ST_START:  state_d = ST_DATA;
            ST_DATA: begin
               if (bit_q == last_bit_q) state_d = par_en_q ? ST_PARITY : ST_STOP;
               else                     bit_d   = bit_q + 1'b1;
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
               if (stop_q == two_stop_q) state_d = ST_IDLE;
               else                      stop_d  = 1'b1;
            end
            default:   state_d = state_q;
         endcase
      end

      // txd is registered from the upcoming state so the line moves on the same edge as the FSM.
      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = data_d[bit_d];
         ST_PARITY: txd_d = par_bit;
         default:   txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         per_q      <= CNT_W'(2);
         bit_q      <= '0;
         last_bit_q <= 3'd7;
         data_q     <= '0;
         stop_q     <= 1'b0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         two_stop_q <= 1'b0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         per_q      <= per_d;
         bit_q      <= bit_d;
         last_bit_q <= last_bit_d;
         data_q     <= data_d;
         stop_q     <= stop_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         two_stop_q <= two_stop_d;
         txd_q      <= txd_d;
      end
   end

endmodule
